// File: rtl/sram_march_bist_if.sv
// Pin bundle between the March BIST initiator and a byte_sram port.
// The BIST drives strobes, address and write data; the SRAM returns read data.
interface sram_march_bist_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              wr_enable;
    logic              rd_enable;
    logic [ADDR_W-1:0] ram_index;
    logic [DATA_W-1:0] sram_data_in;
    logic [DATA_W-1:0] sram_data_out;

    modport master (
        output wr_enable,
        output rd_enable,
        output ram_index,
        output sram_data_in,
        input  sram_data_out
    );

    modport slave (
        input  wr_enable,
        input  rd_enable,
        input  ram_index,
        input  sram_data_in,
        output sram_data_out
    );
endinterface

// File: rtl/sram_march_bist.sv
// March BIST for byte_sram: up W P; up R P,W ~P; down R ~P,W P; up R P.
// Read data is compared on the edge after the read edge; the first miscompare is latched.
module sram_march_bist #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic                 sram_clk,
    input  logic                 sram_ares,
    input  logic                 start,
    input  logic [DATA_W-1:0]    pattern,
    sram_march_bist_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [ADDR_W-1:0]    fail_index,
    output logic [DATA_W-1:0]    fail_data,
    output logic [7:0]           err_count
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_M0    = 3'd1,
        ST_M1    = 3'd2,
        ST_M2    = 3'd3,
        ST_M3    = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] FIRST_IDX = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    state_t              state_r;
    logic [DATA_W-1:0]   p_r;
    logic                wr_r;
    logic                rd_r;
    logic [ADDR_W-1:0]   idx_r;
    logic [DATA_W-1:0]   din_r;
    logic [DATA_W-1:0]   rd_exp_r;
    logic                cmp_pend_r;
    logic [DATA_W-1:0]   cmp_exp_r;
    logic [ADDR_W-1:0]   cmp_idx_r;
    logic                busy_r;
    logic                done_r;
    logic                fail_r;
    logic [ADDR_W-1:0]   fail_idx_r;
    logic [DATA_W-1:0]   fail_data_r;
    logic [7:0]          err_r;
    logic                miscmp_s;

    // A compare is pending for exactly one edge after every read edge.
    assign miscmp_s = cmp_pend_r && (bus.sram_data_out != cmp_exp_r);

    assign bus.wr_enable    = wr_r;
    assign bus.rd_enable    = rd_r;
    assign bus.ram_index    = idx_r;
    assign bus.sram_data_in = din_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign fail       = fail_r;
    assign fail_index = fail_idx_r;
    assign fail_data  = fail_data_r;
    assign err_count  = err_r;

    // March sequencer: each state names the cycle in progress; outputs are set for the next one.
    always_ff @(posedge sram_clk or posedge sram_ares) begin
        if (sram_ares) begin
            state_r     <= ST_IDLE;
            p_r         <= {DATA_W{1'b0}};
            wr_r        <= 1'b0;
            rd_r        <= 1'b0;
            idx_r       <= {ADDR_W{1'b0}};
            din_r       <= {DATA_W{1'b0}};
            rd_exp_r    <= {DATA_W{1'b0}};
            cmp_pend_r  <= 1'b0;
            cmp_exp_r   <= {DATA_W{1'b0}};
            cmp_idx_r   <= {ADDR_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            fail_idx_r  <= {ADDR_W{1'b0}};
            fail_data_r <= {DATA_W{1'b0}};
            err_r       <= 8'd0;
        end else begin
            done_r     <= 1'b0;
            cmp_pend_r <= rd_r;
            cmp_exp_r  <= rd_exp_r;
            cmp_idx_r  <= idx_r;

            if (miscmp_s) begin
                if (err_r != 8'hFF) begin
                    err_r <= err_r + 8'd1;
                end
                if (!fail_r) begin
                    fail_r      <= 1'b1;
                    fail_idx_r  <= cmp_idx_r;
                    fail_data_r <= bus.sram_data_out;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    wr_r <= 1'b0;
                    rd_r <= 1'b0;
                    if (start) begin
                        state_r     <= ST_M0;
                        p_r         <= pattern;
                        busy_r      <= 1'b1;
                        fail_r      <= 1'b0;
                        fail_idx_r  <= {ADDR_W{1'b0}};
                        fail_data_r <= {DATA_W{1'b0}};
                        err_r       <= 8'd0;
                        wr_r        <= 1'b1;
                        idx_r       <= FIRST_IDX;
                        din_r       <= pattern;
                    end
                end
                ST_M0: begin
                    if (idx_r == LAST_IDX) begin
                        state_r  <= ST_M1;
                        wr_r     <= 1'b0;
                        rd_r     <= 1'b1;
                        idx_r    <= FIRST_IDX;
                        rd_exp_r <= p_r;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_M1: begin
                    if (rd_r) begin
                        rd_r  <= 1'b0;
                        wr_r  <= 1'b1;
                        din_r <= ~p_r;
                    end else if (idx_r == LAST_IDX) begin
                        // M2 starts at the top index, so the address is simply held.
                        state_r  <= ST_M2;
                        wr_r     <= 1'b0;
                        rd_r     <= 1'b1;
                        rd_exp_r <= ~p_r;
                    end else begin
                        wr_r     <= 1'b0;
                        rd_r     <= 1'b1;
                        idx_r    <= idx_r + IDX_ONE;
                        rd_exp_r <= p_r;
                    end
                end
                ST_M2: begin
                    if (rd_r) begin
                        rd_r  <= 1'b0;
                        wr_r  <= 1'b1;
                        din_r <= p_r;
                    end else if (idx_r == FIRST_IDX) begin
                        state_r  <= ST_M3;
                        wr_r     <= 1'b0;
                        rd_r     <= 1'b1;
                        rd_exp_r <= p_r;
                    end else begin
                        wr_r     <= 1'b0;
                        rd_r     <= 1'b1;
                        idx_r    <= idx_r - IDX_ONE;
                        rd_exp_r <= ~p_r;
                    end
                end
                ST_M3: begin
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_DRAIN;
                        rd_r    <= 1'b0;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_IDLE;
                    wr_r    <= 1'b0;
                    rd_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    wr_r    <= 1'b0;
                    rd_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist with a byte_sram model and fault injection.
// Expected run results are queued at start and popped when done is observed.
module tb_sram_march_bist;
    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int N   = 1 << AW;
    localparam int LAT = 6 * N + 1;

    typedef struct {
        int         lat;
        logic       fail;
        logic [6:0] fidx;
        logic [7:0] fdata;
        logic [7:0] errc;
    } exp_t;

    logic          sram_clk  = 1'b0;
    logic          sram_ares = 1'b1;
    logic          start     = 1'b0;
    logic [DW-1:0] pattern   = 8'h00;
    logic          busy, done, fail;
    logic [AW-1:0] fail_index;
    logic [DW-1:0] fail_data;
    logic [7:0]    err_count;

    int n_total = 0;
    int n_pass  = 0;
    int both_cnt = 0;
    int strobe_cnt = 0;
    int fault_mode = 0;
    logic [AW-1:0] fault_idx  = 7'h00;
    logic [DW-1:0] fault_mask = 8'h00;
    logic [DW-1:0] mem [N];
    exp_t sb[$];

    sram_march_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .sram_clk   (sram_clk),
        .sram_ares  (sram_ares),
        .start      (start),
        .pattern    (pattern),
        .bus        (bus_if.master),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_index (fail_index),
        .fail_data  (fail_data),
        .err_count  (err_count)
    );

    always #5 sram_clk = ~sram_clk;

    function automatic logic [DW-1:0] faulted(input logic [AW-1:0] i, input logic [DW-1:0] d);
        if (fault_mode == 2) return 8'h00;
        if (fault_mode == 1 && i == fault_idx) return d & ~fault_mask;
        return d;
    endfunction

    // byte_sram model plus strobe monitors
    always @(posedge sram_clk) begin
        if (bus_if.wr_enable && !bus_if.rd_enable) begin
            mem[bus_if.ram_index] <= faulted(bus_if.ram_index, bus_if.sram_data_in);
            bus_if.sram_data_out  <= 8'h00;
        end else if (bus_if.rd_enable && !bus_if.wr_enable) begin
            bus_if.sram_data_out <= mem[bus_if.ram_index];
        end else begin
            bus_if.sram_data_out <= 8'h00;
        end
        if (bus_if.wr_enable && bus_if.rd_enable) both_cnt <= both_cnt + 1;
        if (bus_if.wr_enable || bus_if.rd_enable) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_mem(input string tag, input logic [DW-1:0] val);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== val) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    task automatic run_test(input string tag, input logic [DW-1:0] p, input int restart_at, input exp_t e);
        int   cyc = 0;
        bit   seen = 1'b0;
        int   b0 = both_cnt;
        exp_t got;
        sb.push_back(e);
        @(negedge sram_clk);
        start = 1'b1;
        pattern = p;
        @(negedge sram_clk);
        start = 1'b0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        while (!seen && cyc < LAT + 200) begin
            @(negedge sram_clk);
            cyc++;
            start = 1'b0;
            if (cyc == restart_at) begin
                start = 1'b1;
                pattern = 8'h00;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        got = sb.pop_front();
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(got.lat));
        check({tag, "_fail"}, 64'(fail), 64'(got.fail));
        check({tag, "_fail_index"}, 64'(fail_index), 64'(got.fidx));
        check({tag, "_fail_data"}, 64'(fail_data), 64'(got.fdata));
        check({tag, "_err_count"}, 64'(err_count), 64'(got.errc));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        check({tag, "_wr_rd_overlap"}, 64'(both_cnt - b0), 64'd0);
        @(negedge sram_clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        exp_t e;
        int   done_cnt;

        // 1: reset held, start pulsed
        repeat (2) @(negedge sram_clk);
        start = 1'b1;
        pattern = 8'h5A;
        @(negedge sram_clk);
        start = 1'b0;
        @(negedge sram_clk);
        check("rst_outputs", {bus_if.wr_enable, bus_if.rd_enable, bus_if.ram_index, bus_if.sram_data_in,
                              busy, done, fail, fail_index, fail_data, err_count}, 64'd0);
        check("rst_no_strobes", 64'(strobe_cnt), 64'd0);
        sram_ares = 1'b0;
        repeat (3) @(negedge sram_clk);
        check("idle_after_rst", {busy, done, bus_if.wr_enable, bus_if.rd_enable}, 64'd0);

        // 2: fault-free
        e = '{lat: LAT, fail: 1'b0, fidx: 7'h00, fdata: 8'h00, errc: 8'd0};
        run_test("clean55", 8'h55, 0, e);
        check_mem("clean55_mem", 8'h55);

        // 3: bit3 stuck-at-0 at index 0x10
        fault_mode = 1;
        fault_idx  = 7'h10;
        fault_mask = 8'h08;
        e = '{lat: LAT, fail: 1'b1, fidx: 7'h10, fdata: 8'hA2, errc: 8'd1};
        run_test("sa0", 8'h55, 0, e);

        // 4: every location reads 0, pattern FF -> 256 miscompares, saturated
        fault_mode = 2;
        e = '{lat: LAT, fail: 1'b1, fidx: 7'h00, fdata: 8'h00, errc: 8'd255};
        run_test("allzero", 8'hFF, 0, e);

        // 5: restart mid-run with a different pattern is ignored
        fault_mode = 0;
        e = '{lat: LAT, fail: 1'b0, fidx: 7'h00, fdata: 8'h00, errc: 8'd0};
        run_test("restart", 8'h55, 100, e);
        check_mem("restart_mem", 8'h55);

        // 6: reset mid-run aborts without done
        @(negedge sram_clk);
        start = 1'b1;
        pattern = 8'h55;
        @(negedge sram_clk);
        start = 1'b0;
        repeat (300) @(negedge sram_clk);
        sram_ares = 1'b1;
        #1;
        check("abort_outputs", {bus_if.wr_enable, bus_if.rd_enable, bus_if.ram_index, bus_if.sram_data_in,
                                busy, done, fail, fail_index, fail_data, err_count}, 64'd0);
        @(negedge sram_clk);
        sram_ares = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge sram_clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        e = '{lat: LAT, fail: 1'b0, fidx: 7'h00, fdata: 8'h00, errc: 8'd0};
        run_test("after_abort", 8'h55, 0, e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
